button_conditioner: RTL and testbench

- Multi-channel successor to the single-input debouncer. Conditions N asynchronous push-button or switch inputs into clean levels and single-cycle event pulses.
- Per channel:
  - two-flop synchroniser
  - parametrised debounce filter, with an optional strict mode that aborts on a glitch
  - rise/fall edge pulses
  - auto-repeat pulses while a button is held
- Sits between board I/O and the graphics/control FSMs, which consume pulses rather than raw levels.

---
 rtl/button_pkg.sv | 19 +
 rtl/button_channel.sv | 132 +++++++++++++
 rtl/button_conditioner.sv | 37 +++
 tb/tb_button_conditioner.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared types and width helpers for the multi-channel button conditioner.
package button_pkg;

  typedef enum logic [1:0] {
    S_0       = 2'b00,
    S_MAYBE_1 = 2'b01,
    S_1       = 2'b10,
    S_MAYBE_0 = 2'b11
  } debounce_state_t;

  function automatic int cnt_width(input int bounce_ticks);
    return $clog2(bounce_ticks) + 1;
  endfunction

  function automatic int hold_width(input int hold_ticks, input int repeat_ticks);
    return $clog2(hold_ticks + repeat_ticks) + 1;
  endfunction

endpackage

// File: rtl/button_channel.sv
// One conditioned button: 2-flop synchroniser, debounce FSM, edge pulses and
// auto-repeat. All outputs are registered or decoded from registered state.
module button_channel
  import button_pkg::*;
#(
  parameter int BOUNCE_TICKS = 10,
  parameter int STRICT       = 0,
  parameter int HOLD_TICKS   = 0,
  parameter int REPEAT_TICKS = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic bouncy_in,
  output logic level_out,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic repeat_pulse
);

  localparam int CW = cnt_width(BOUNCE_TICKS);
  localparam int HW = hold_width(HOLD_TICKS, REPEAT_TICKS);
  localparam int RW = $clog2(REPEAT_TICKS) + 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(BOUNCE_TICKS - 1);
  localparam logic [HW-1:0] HOLD_LAST = (HOLD_TICKS > 0) ? HW'(HOLD_TICKS - 1) : '0;
  localparam logic [HW-1:0] HOLD_MAX  = '1;
  localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_TICKS - 1);
  localparam bit STRICT_EN = (STRICT != 0);
  localparam bit REPEAT_EN = (HOLD_TICKS != 0);

  logic [1:0]      sync_q;
  logic            sync_in;
  debounce_state_t state, state_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic [HW-1:0]   hold_cnt, hold_d;
  logic [RW-1:0]   rep_cnt, rep_d;
  logic            armed, armed_d;
  logic            rep_fire;
  logic            rise_q, fall_q, repeat_q;

  assign sync_in = sync_q[1];

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      S_0: begin
        if (sync_in) begin
          state_d = S_MAYBE_1;
          cnt_d   = '0;
        end
      end
      S_MAYBE_1: begin
        cnt_d = cnt + 1'b1;
        if (STRICT_EN && !sync_in) state_d = S_0;
        else if (cnt == CNT_LAST)  state_d = sync_in ? S_1 : S_0;
      end
      S_1: begin
        if (!sync_in) begin
          state_d = S_MAYBE_0;
          cnt_d   = '0;
        end
      end
      S_MAYBE_0: begin
        cnt_d = cnt + 1'b1;
        if (STRICT_EN && sync_in) state_d = S_1;
        else if (cnt == CNT_LAST) state_d = sync_in ? S_1 : S_0;
      end
      default: begin
        state_d = S_0;
        cnt_d   = '0;
      end
    endcase
  end

  // hold_cnt only advances while staying in S_1, so it is frozen across a
  // failed release window; after the first repeat rep_cnt sets the period.
  always_comb begin
    hold_d   = hold_cnt;
    rep_d    = rep_cnt;
    armed_d  = armed;
    rep_fire = 1'b0;
    if (state == S_MAYBE_1 && state_d == S_1) begin
      hold_d  = '0;
      rep_d   = '0;
      armed_d = 1'b0;
    end else if (REPEAT_EN && state == S_1 && state_d == S_1) begin
      hold_d = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + 1'b1;
      if (!armed) begin
        if (hold_d >= HOLD_LAST) begin
          rep_fire = 1'b1;
          armed_d  = 1'b1;
          rep_d    = '0;
        end
      end else if (rep_cnt == REP_LAST) begin
        rep_fire = 1'b1;
        rep_d    = '0;
      end else begin
        rep_d = rep_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= '0;
      state    <= S_0;
      cnt      <= '0;
      hold_cnt <= '0;
      rep_cnt  <= '0;
      armed    <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      repeat_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], bouncy_in};
      state    <= state_d;
      cnt      <= cnt_d;
      hold_cnt <= hold_d;
      rep_cnt  <= rep_d;
      armed    <= armed_d;
      rise_q   <= (state == S_MAYBE_1) && (state_d == S_1);
      fall_q   <= (state == S_MAYBE_0) && (state_d == S_0);
      repeat_q <= rep_fire;
    end
  end

  assign level_out    = (state == S_1) || (state == S_MAYBE_0);
  assign rise_pulse   = rise_q;
  assign fall_pulse   = fall_q;
  assign repeat_pulse = repeat_q;

endmodule

// File: rtl/button_conditioner.sv
// N independent button channels; the top level only replicates and wires them.
module button_conditioner
  import button_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int BOUNCE_TICKS = 10,
  parameter int STRICT       = 0,
  parameter int HOLD_TICKS   = 0,
  parameter int REPEAT_TICKS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] bouncy_in,
  output logic [N_CH-1:0] level_out,
  output logic [N_CH-1:0] rise_pulse,
  output logic [N_CH-1:0] fall_pulse,
  output logic [N_CH-1:0] repeat_pulse
);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    button_channel #(
      .BOUNCE_TICKS(BOUNCE_TICKS),
      .STRICT      (STRICT),
      .HOLD_TICKS  (HOLD_TICKS),
      .REPEAT_TICKS(REPEAT_TICKS)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .bouncy_in   (bouncy_in[g]),
      .level_out   (level_out[g]),
      .rise_pulse  (rise_pulse[g]),
      .fall_pulse  (fall_pulse[g]),
      .repeat_pulse(repeat_pulse[g])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench: two conditioners (lenient with auto-repeat, strict without) share one
// input bus; expected pulse events are queued with their due cycle.
module tb_button_conditioner;

  localparam int K_RISE = 0;
  localparam int K_FALL = 1;
  localparam int K_REP  = 2;
  localparam int D_A    = 0;
  localparam int D_B    = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] bouncy = '0;
  logic [3:0] lvl_a, rise_a, fall_a, rep_a;
  logic [3:0] lvl_b, rise_b, fall_b, rep_b;

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  logic [39:0] exp_q[$];

  button_conditioner #(
    .N_CH(4), .BOUNCE_TICKS(4), .STRICT(0), .HOLD_TICKS(8), .REPEAT_TICKS(3)
  ) dut_a (
    .clk(clk), .rst(rst), .bouncy_in(bouncy),
    .level_out(lvl_a), .rise_pulse(rise_a), .fall_pulse(fall_a), .repeat_pulse(rep_a)
  );

  button_conditioner #(
    .N_CH(4), .BOUNCE_TICKS(4), .STRICT(1), .HOLD_TICKS(0), .REPEAT_TICKS(1)
  ) dut_b (
    .clk(clk), .rst(rst), .bouncy_in(bouncy),
    .level_out(lvl_b), .rise_pulse(rise_b), .fall_pulse(fall_b), .repeat_pulse(rep_b)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [39:0] mk_ev(input int t, input int d, input int k, input int ch);
    return {t[31:0], d[1:0], k[1:0], ch[3:0]};
  endfunction

  function automatic logic pulse_bit(input int d, input int k, input int ch);
    logic [3:0] v;
    if (d == D_A) v = (k == K_RISE) ? rise_a : (k == K_FALL) ? fall_a : rep_a;
    else          v = (k == K_RISE) ? rise_b : (k == K_FALL) ? fall_b : rep_b;
    return v[ch];
  endfunction

  // scoreboard: every observed pulse must match a queued event for this cycle,
  // and every queued event due this cycle must have been observed
  always @(negedge clk) begin
    int idx;
    logic [39:0] ev;
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 3; k++)
        for (int ch = 0; ch < 4; ch++)
          if (pulse_bit(d, k, ch)) begin
            idx = -1;
            foreach (exp_q[i]) if (exp_q[i] == mk_ev(cyc, d, k, ch)) idx = i;
            checks++;
            assert (idx >= 0) else begin
              failures++;
              $error("FAIL pulse_unexpected dut=%0d kind=%0d ch=%0d cyc=%0d observed=1 expected=0",
                     d, k, ch, cyc);
            end
            if (idx >= 0) exp_q.delete(idx);
          end
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      ev = exp_q[i];
      if (int'(ev[39:8]) <= cyc) begin
        checks++;
        assert (pulse_bit(int'(ev[7:6]), int'(ev[5:4]), int'(ev[3:0])) === 1'b1) else begin
          failures++;
          $error("FAIL pulse_missing dut=%0d kind=%0d ch=%0d cyc=%0d observed=0 expected=1",
                 ev[7:6], ev[5:4], ev[3:0], cyc);
        end
        exp_q.delete(i);
      end
    end
  end

  // driver tasks
  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic set_ch(input int ch, input logic v);
    bouncy[ch] = v;
  endtask

  task automatic push_both(input int t, input int k, input int ch);
    exp_q.push_back(mk_ev(t, D_A, k, ch));
    exp_q.push_back(mk_ev(t, D_B, k, ch));
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk_vec({tag, "_lvl_a"}, lvl_a, 4'b0);
    chk_vec({tag, "_lvl_b"}, lvl_b, 4'b0);
    chk_vec({tag, "_pulses_a"}, rise_a | fall_a | rep_a, 4'b0);
    chk_vec({tag, "_pulses_b"}, rise_b | fall_b | rep_b, 4'b0);
  endtask

  // clean press of len cycles on one channel, all others idle
  task automatic clean_press(input int ch, input int len);
    int c, e, d;
    c = cyc;
    e = c + 7;
    d = c + len;
    set_ch(ch, 1'b1);
    push_both(e, K_RISE, ch);
    for (int t = e + 7; t <= d + 2; t += 3) exp_q.push_back(mk_ev(t, D_A, K_REP, ch));
    push_both(d + 7, K_FALL, ch);
    wait_to(c + 6);
    chk_bit($sformatf("press_lvl_pre_a ch%0d", ch), lvl_a[ch], 1'b0);
    chk_bit($sformatf("press_lvl_pre_b ch%0d", ch), lvl_b[ch], 1'b0);
    wait_to(c + 7);
    chk_bit($sformatf("press_lvl_a ch%0d", ch), lvl_a[ch], 1'b1);
    chk_bit($sformatf("press_lvl_b ch%0d", ch), lvl_b[ch], 1'b1);
    wait_to(d);
    set_ch(ch, 1'b0);
    wait_to(d + 6);
    chk_bit($sformatf("release_lvl_pre_a ch%0d", ch), lvl_a[ch], 1'b1);
    wait_to(d + 7);
    chk_bit($sformatf("release_lvl_a ch%0d", ch), lvl_a[ch], 1'b0);
    chk_bit($sformatf("release_lvl_b ch%0d", ch), lvl_b[ch], 1'b0);
    wait_to(d + 9);
  endtask

  initial begin
    int c, c0, g;
    @(negedge clk);
    wait_to(3);
    chk_all_zero("reset_hold");
    rst = 1'b0;
    wait_to(cyc + 3);
    chk_all_zero("after_reset");

    // steady press on ch0 with a 20-cycle hold: repeats at hold_cnt 7..19
    clean_press(0, 24);

    // bouncy 1,0,1,1,... on ch1: lenient accepts at once, strict restarts
    c = cyc;
    set_ch(1, 1'b1);
    exp_q.push_back(mk_ev(c + 7, D_A, K_RISE, 1));
    exp_q.push_back(mk_ev(c + 9, D_B, K_RISE, 1));
    push_both(c + 15, K_FALL, 1);
    wait_to(c + 1); set_ch(1, 1'b0);
    wait_to(c + 2); set_ch(1, 1'b1);
    wait_to(c + 7);
    chk_bit("toggle_lvl_a", lvl_a[1], 1'b1);
    wait_to(c + 8);
    chk_bit("toggle_lvl_b_pre", lvl_b[1], 1'b0);
    set_ch(1, 1'b0);
    wait_to(c + 9);
    chk_bit("toggle_lvl_b", lvl_b[1], 1'b1);
    wait_to(c + 17);

    // 2-cycle low glitch on ch2 while held: no fall, hold_cnt frozen
    c = cyc;
    set_ch(2, 1'b1);
    push_both(c + 7, K_RISE, 2);
    exp_q.push_back(mk_ev(c + 19, D_A, K_REP, 2));
    push_both(c + 25, K_FALL, 2);
    wait_to(c + 10); set_ch(2, 1'b0);
    wait_to(c + 12); set_ch(2, 1'b1);
    for (int t = c + 13; t <= c + 18; t++) begin
      wait_to(t);
      chk_bit($sformatf("glitch_lvl_a t%0d", t - c), lvl_a[2], 1'b1);
      chk_bit($sformatf("glitch_lvl_b t%0d", t - c), lvl_b[2], 1'b1);
    end
    set_ch(2, 1'b0);
    wait_to(c + 27);

    // reset mid-window on ch3 (cnt=2) while ch0 is already pressed
    c0 = cyc;
    set_ch(0, 1'b1);
    push_both(c0 + 7, K_RISE, 0);
    wait_to(c0 + 8);
    c = cyc;
    set_ch(3, 1'b1);
    wait_to(c + 5);
    chk_bit("prereset_lvl_a0", lvl_a[0], 1'b1);
    rst = 1'b1;
    wait_to(c + 6);
    chk_all_zero("mid_reset");
    rst = 1'b0;
    push_both(c + 13, K_RISE, 0);
    push_both(c + 13, K_RISE, 3);
    push_both(c + 21, K_FALL, 0);
    push_both(c + 21, K_FALL, 3);
    wait_to(c + 12);
    chk_vec("postreset_lvl_a_pre", lvl_a, 4'b0000);
    chk_vec("postreset_lvl_b_pre", lvl_b, 4'b0000);
    wait_to(c + 13);
    chk_vec("postreset_lvl_a", lvl_a, 4'b1001);
    chk_vec("postreset_lvl_b", lvl_b, 4'b1001);
    wait_to(c + 14);
    set_ch(0, 1'b0);
    set_ch(3, 1'b0);
    wait_to(c + 23);

    // staggered presses on all channels, common release
    c = cyc;
    for (int i = 0; i < 4; i++) begin
      wait_to(c + i);
      set_ch(i, 1'b1);
      push_both(c + i + 7, K_RISE, i);
      push_both(c + 15, K_FALL, i);
    end
    wait_to(c + 8);
    bouncy = 4'b0000;
    wait_to(c + 9);
    chk_vec("stagger_lvl_a", lvl_a, 4'b0111);
    chk_vec("stagger_lvl_b", lvl_b, 4'b0111);
    wait_to(c + 10);
    chk_vec("stagger_all_a", lvl_a, 4'b1111);
    chk_vec("stagger_all_b", lvl_b, 4'b1111);
    wait_to(c + 17);

    // long hold to push hold_cnt into saturation, then random presses
    clean_press(1, 60);
    for (int i = 0; i < 5; i++) begin
      g = $urandom_range(0, 3);
      clean_press(g, $urandom_range(8, 45));
    end

    wait_to(cyc + 5);
    checks++;
    assert (exp_q.size() === 0) else begin
      failures++;
      $error("FAIL queue_empty observed=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
